// File: rtl/ext_mem_seq.sv
// External-memory access sequencer: turns single-cycle core requests into a
// registered setup / strobe / hold bus sequence with read capture and ack pulse.
module ext_mem_seq #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned WAIT_W    = 3
) (
    input  logic              ext_mem_seq_clk_i,
    input  logic              ext_mem_seq_rst_b_i,
    input  logic              ext_mem_seq_req_i,
    input  logic [1:0]        ext_mem_seq_type_i,
    input  logic [15:0]       ext_mem_seq_addr_i,
    input  logic [7:0]        ext_mem_seq_wdata_i,
    input  logic [WAIT_W-1:0] ext_mem_seq_wait_i,
    input  logic [7:0]        ext_mem_seq_ext_data_i,
    output logic              ext_mem_seq_ack_o,
    output logic              ext_mem_seq_busy_o,
    output logic [7:0]        ext_mem_seq_rdata_o,
    output logic [15:0]       ext_mem_seq_ext_addr_o,
    output logic [7:0]        ext_mem_seq_ext_data_o,
    output logic              ext_mem_seq_ext_rom_rd_b_o,
    output logic              ext_mem_seq_ext_ram_rd_b_o,
    output logic              ext_mem_seq_ext_ram_wr_b_o
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

    localparam logic [1:0] TYPE_ROM_RD = 2'b00;
    localparam logic [1:0] TYPE_RAM_RD = 2'b01;
    localparam logic [1:0] TYPE_RAM_WR = 2'b10;
    localparam logic [1:0] TYPE_RSVD   = 2'b11;

    // One shared down-counter times setup, strobe and hold phases.
    localparam int unsigned CNT_W = (WAIT_W > 3) ? WAIT_W : 3;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        type_q, type_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        data_out_q, data_out_d;
    logic [2:0]        strb_q, strb_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    always_ff @(posedge ext_mem_seq_clk_i or negedge ext_mem_seq_rst_b_i) begin
        if (!ext_mem_seq_rst_b_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            type_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            data_out_q <= '0;
            strb_q     <= '1;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            data_out_q <= data_out_d;
            strb_q     <= strb_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (ext_mem_seq_req_i && ext_mem_seq_type_i != TYPE_RSVD) begin
                    type_d  = ext_mem_seq_type_i;
                    addr_d  = ext_mem_seq_addr_i;
                    wdata_d = ext_mem_seq_wdata_i;
                    wait_d  = ext_mem_seq_wait_i;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(wait_q);
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (type_q != TYPE_RAM_WR) begin
                        rdata_d = ext_mem_seq_ext_data_i;
                    end
                    if (HOLD_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = HOLD_LD;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the FSM enters each phase.
        busy_d     = (state_d != IDLE);
        ack_d      = (state_q != IDLE) && (state_d == IDLE);
        data_out_d = (state_d != IDLE && type_d == TYPE_RAM_WR) ? wdata_d : 8'h00;
        strb_d     = 3'b111;
        if (state_d == STROBE) begin
            case (type_d)
                TYPE_ROM_RD: strb_d = 3'b011;
                TYPE_RAM_RD: strb_d = 3'b101;
                TYPE_RAM_WR: strb_d = 3'b110;
                default:     strb_d = 3'b111;
            endcase
        end
    end

    assign ext_mem_seq_ack_o          = ack_q;
    assign ext_mem_seq_busy_o         = busy_q;
    assign ext_mem_seq_rdata_o        = rdata_q;
    assign ext_mem_seq_ext_addr_o     = addr_q;
    assign ext_mem_seq_ext_data_o     = data_out_q;
    assign ext_mem_seq_ext_rom_rd_b_o = strb_q[2];
    assign ext_mem_seq_ext_ram_rd_b_o = strb_q[1];
    assign ext_mem_seq_ext_ram_wr_b_o = strb_q[0];

endmodule
